// File: rtl/toeplitz_colstream.sv
// Streaming Toeplitz column generator for the privacy-amplification datapath.
// It holds an N+L-1 bit seed and emits columns 0, STRIDE, ..., N-STRIDE, one
// per valid/ready beat. Passes can run single-shot or wrap continuously, and
// a pass can be aborted. A pass counter records the completed passes.
//
// Optional feature (macro TOEPLITZ_SHADOW_SEED_EN): a shadow seed register
// accepts one new seed while a pass is running. The new seed takes effect
// from column 0 of the pass that follows the next last beat or abort.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no seed held; waiting for the first seed
// ST_ARMED | seed loaded; waiting for start (seeds may still be reloaded)
// ST_RUN   | streaming columns; out_valid = busy = 1
module toeplitz_colstream #(
    parameter  int N      = 256,
    parameter  int L      = 128,
    parameter  int STRIDE = 1,
    parameter  int PCW    = 16,
    localparam int SW     = N + L - 1,
    localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SW-1:0]   seed,
    input  logic            seed_valid,
    output logic            seed_ready,
    input  logic            start,
    input  logic            cont,
    input  logic            abort,
    output logic [L-1:0]    out_col,
    output logic [IW-1:0]   out_idx,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic            busy,
    output logic [PCW-1:0]  pass_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   seed_reg_q, seed_reg_d;
    logic [SW-1:0]   sr_q, sr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [PCW-1:0]  pass_cnt_q, pass_cnt_d;
    logic            run;
    logic            at_last;
    logic            seed_acc;

`ifdef TOEPLITZ_SHADOW_SEED_EN
    logic [SW-1:0]   shadow_q, shadow_d;
    logic            pending_q, pending_d;
`endif

    assign run      = (state_q == ST_RUN);
    // With STRIDE == N the only index ever seen is 0, so every beat is last.
    assign at_last  = (idx_q == IW'(N - STRIDE));

`ifdef TOEPLITZ_SHADOW_SEED_EN
    assign seed_ready = run ? ~pending_q : 1'b1;
`else
    assign seed_ready = ~run;
`endif

    assign seed_acc  = seed_valid & seed_ready;
    assign out_col   = sr_q[L-1:0];
    assign out_idx   = idx_q;
    assign out_valid = run;
    assign busy      = run;
    assign out_last  = run & at_last;
    assign pass_cnt  = pass_cnt_q;

    // Next-state and datapath updates for seed load, streaming, wrap and abort.
    always_comb begin
        state_d    = state_q;
        seed_reg_d = seed_reg_q;
        sr_d       = sr_q;
        idx_d      = idx_q;
        pass_cnt_d = pass_cnt_q;
`ifdef TOEPLITZ_SHADOW_SEED_EN
        shadow_d   = shadow_q;
        pending_d  = pending_q;
`endif
        case (state_q)
            ST_IDLE, ST_ARMED: begin
                if (seed_acc) begin
                    seed_reg_d = seed;
                    sr_d       = seed;
                    idx_d      = '0;
                    state_d    = ST_ARMED;
                end
                // start and a seed accept together: RUN begins on the new seed.
                if (state_q == ST_ARMED && start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // The beat presented this cycle is dropped, not consumed.
                    state_d = ST_ARMED;
                    sr_d    = seed_reg_q;
                    idx_d   = '0;
`ifdef TOEPLITZ_SHADOW_SEED_EN
                    if (pending_q) begin
                        seed_reg_d = shadow_q;
                        sr_d       = shadow_q;
                        pending_d  = 1'b0;
                    end
`endif
                end else if (out_ready) begin
                    if (at_last) begin
                        pass_cnt_d = pass_cnt_q + PCW'(1);
                        sr_d       = seed_reg_q;
                        idx_d      = '0;
                        state_d    = cont ? ST_RUN : ST_ARMED;
`ifdef TOEPLITZ_SHADOW_SEED_EN
                        if (pending_q) begin
                            seed_reg_d = shadow_q;
                            sr_d       = shadow_q;
                            pending_d  = 1'b0;
                        end
`endif
                    end else begin
                        sr_d  = sr_q >> STRIDE;
                        idx_d = idx_q + IW'(STRIDE);
                    end
                end
`ifdef TOEPLITZ_SHADOW_SEED_EN
                // Only taken when nothing is pending, so it never races the swap above.
                if (seed_acc) begin
                    shadow_d  = seed;
                    pending_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            seed_reg_q <= '0;
            sr_q       <= '0;
            idx_q      <= '0;
            pass_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            seed_reg_q <= seed_reg_d;
            sr_q       <= sr_d;
            idx_q      <= idx_d;
            pass_cnt_q <= pass_cnt_d;
        end
    end

`ifdef TOEPLITZ_SHADOW_SEED_EN
    // Shadow seed holding register and its pending flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end
`endif

endmodule

// File: tb/tb_toeplitz_colstream.sv
// Testbench for toeplitz_colstream: three small instances (STRIDE 1, 2 and N)
// with hand-computed columns pushed into per-instance queues; monitors pop and
// compare on each accepted beat.
module tb_toeplitz_colstream;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

`ifdef TOEPLITZ_SHADOW_SEED_EN
    localparam bit USE_F = 1'b1;
`else
    localparam bit USE_F = 1'b0;
`endif

    logic [3:0] tab5 [8] = '{4'h3, 4'h1, 4'h8, 4'h4, 4'hA, 4'hD, 4'h6, 4'hB};

    // Instance A: N=8, L=4, STRIDE=1
    logic [10:0] a_seed = '0;
    logic a_seed_valid = 0, a_start = 0, a_cont = 0, a_abort = 0, a_out_ready = 1;
    logic a_seed_ready, a_out_valid, a_out_last, a_busy;
    logic [3:0] a_out_col;
    logic [2:0] a_out_idx;
    logic [15:0] a_pass;

    // Instances B (STRIDE=2) and C (STRIDE=8) share stimulus except cont.
    logic [10:0] b_seed = '0;
    logic b_seed_valid = 0, b_start = 0, b_cont = 0, c_cont = 0, b_abort = 0, b_out_ready = 1;
    logic b_seed_ready, b_out_valid, b_out_last, b_busy;
    logic c_seed_ready, c_out_valid, c_out_last, c_busy;
    logic [3:0] b_out_col, c_out_col;
    logic [2:0] b_out_idx, c_out_idx;
    logic [15:0] b_pass, c_pass;

    logic [7:0] qa [$];
    logic [7:0] qb [$];
    logic [7:0] qc [$];

    toeplitz_colstream #(.N(8), .L(4), .STRIDE(1), .PCW(16)) dut_a (
        .clk(clk), .reset(reset), .seed(a_seed), .seed_valid(a_seed_valid),
        .seed_ready(a_seed_ready), .start(a_start), .cont(a_cont), .abort(a_abort),
        .out_col(a_out_col), .out_idx(a_out_idx), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_last(a_out_last), .busy(a_busy), .pass_cnt(a_pass));

    toeplitz_colstream #(.N(8), .L(4), .STRIDE(2), .PCW(16)) dut_b (
        .clk(clk), .reset(reset), .seed(b_seed), .seed_valid(b_seed_valid),
        .seed_ready(b_seed_ready), .start(b_start), .cont(b_cont), .abort(b_abort),
        .out_col(b_out_col), .out_idx(b_out_idx), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_last(b_out_last), .busy(b_busy), .pass_cnt(b_pass));

    toeplitz_colstream #(.N(8), .L(4), .STRIDE(8), .PCW(16)) dut_c (
        .clk(clk), .reset(reset), .seed(b_seed), .seed_valid(b_seed_valid),
        .seed_ready(c_seed_ready), .start(b_start), .cont(c_cont), .abort(b_abort),
        .out_col(c_out_col), .out_idx(c_out_idx), .out_valid(c_out_valid),
        .out_ready(b_out_ready), .out_last(c_out_last), .busy(c_busy), .pass_cnt(c_pass));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] colv(input bit use_f, input int j);
        return use_f ? 4'hF : tab5[j];
    endfunction

    function automatic logic [7:0] ent(input logic [3:0] col, input int j, input bit last);
        return {last, 3'(j), col};
    endfunction

    // Monitors: every accepted beat is popped and compared as {last, idx, col}.
    always @(negedge clk) begin
        if (!reset && a_out_valid && a_out_ready && !a_abort) begin
            if (qa.size() == 0) chk("a_unexpected_beat", 32'(a_out_idx), 32'hFFFF);
            else chk("a_beat", 32'({a_out_last, a_out_idx, a_out_col}), 32'(qa.pop_front()));
        end
        if (!reset && b_out_valid && b_out_ready && !b_abort) begin
            if (qb.size() == 0) chk("b_unexpected_beat", 32'(b_out_idx), 32'hFFFF);
            else chk("b_beat", 32'({b_out_last, b_out_idx, b_out_col}), 32'(qb.pop_front()));
        end
        if (!reset && c_out_valid && b_out_ready && !b_abort) begin
            if (qc.size() == 0) chk("c_unexpected_beat", 32'(c_out_idx), 32'hFFFF);
            else chk("c_beat", 32'({c_out_last, c_out_idx, c_out_col}), 32'(qc.pop_front()));
        end
    end

    initial begin
        tick(2);
        reset = 1'b0;
        tick(1);

        // Reset state
        chk("rst_col", 32'(a_out_col), 0);
        chk("rst_idx", 32'(a_out_idx), 0);
        chk("rst_valid", 32'(a_out_valid), 0);
        chk("rst_last", 32'(a_out_last), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_seed_ready", 32'(a_seed_ready), 1);
        chk("rst_pass", 32'(a_pass), 0);

        // start in IDLE is ignored
        a_start = 1; tick(1); a_start = 0;
        chk("idle_start_ignored", 32'(a_busy), 0);

        // Single pass, STRIDE=1
        a_seed = 11'h5A3; a_seed_valid = 1; tick(1); a_seed_valid = 0;
        chk("armed_seed_ready", 32'(a_seed_ready), 1);
        chk("armed_busy", 32'(a_busy), 0);
        chk("armed_col", 32'(a_out_col), 32'h3);
        for (int j = 0; j < 8; j++) qa.push_back(ent(tab5[j], j, j == 7));
        a_start = 1; tick(1); a_start = 0;
        chk("run_valid", 32'(a_out_valid), 1);
        tick(8);
        chk("p1_busy", 32'(a_busy), 0);
        chk("p1_pass", 32'(a_pass), 1);
        chk("p1_seed_ready", 32'(a_seed_ready), 1);
        chk("p1_reload_col", 32'(a_out_col), 32'h3);
        chk("p1_reload_idx", 32'(a_out_idx), 0);

        // Stall for 3 cycles at idx 2
        for (int j = 0; j < 8; j++) qa.push_back(ent(tab5[j], j, j == 7));
        a_start = 1; tick(1); a_start = 0;
        tick(2);
        a_out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_col", 32'(a_out_col), 32'h8);
            chk("stall_idx", 32'(a_out_idx), 2);
            chk("stall_valid", 32'(a_out_valid), 1);
            tick(1);
        end
        a_out_ready = 1;
        tick(6);
        chk("p2_busy", 32'(a_busy), 0);
        chk("p2_pass", 32'(a_pass), 2);

        // Continuous mode for 20 beats, seed offered mid-pass, then abort at idx 4
        for (int k = 0; k < 20; k++)
            qa.push_back(ent(k < 8 ? tab5[k % 8] : colv(USE_F, k % 8), k % 8, (k % 8) == 7));
        a_cont = 1; a_start = 1; tick(1); a_start = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            chk("cont_busy", 32'(a_busy), 1);
            if (k == 3) begin
                a_seed = 11'h7FF; a_seed_valid = 1;
                chk("run_seed_ready", 32'(a_seed_ready), 32'(USE_F));
            end
            if (k == 4) begin
                a_seed_valid = 0;
                chk("run_seed_ready_after", 32'(a_seed_ready), 0);
            end
            if (k == 16) chk("cont_pass", 32'(a_pass), 4);
        end
        chk("abort_pre_idx", 32'(a_out_idx), 4);
        a_abort = 1; a_cont = 0; tick(1); a_abort = 0;
        chk("abort_valid", 32'(a_out_valid), 0);
        chk("abort_busy", 32'(a_busy), 0);
        chk("abort_pass", 32'(a_pass), 4);
        chk("abort_idx", 32'(a_out_idx), 0);
        chk("abort_col", 32'(a_out_col), 32'(colv(USE_F, 0)));
        chk("abort_seed_ready", 32'(a_seed_ready), 1);

        // Restart after abort replays from column 0
        for (int j = 0; j < 8; j++) qa.push_back(ent(colv(USE_F, j), j, j == 7));
        a_start = 1; tick(1); a_start = 0;
        tick(8);
        chk("p5_busy", 32'(a_busy), 0);
        chk("p5_pass", 32'(a_pass), 5);

        // Reset mid-RUN returns to IDLE and discards the seed
        qa.push_back(ent(colv(USE_F, 0), 0, 0));
        qa.push_back(ent(colv(USE_F, 1), 1, 0));
        a_start = 1; tick(1); a_start = 0;
        tick(2);
        reset = 1; tick(1); reset = 0;
        chk("mid_rst_busy", 32'(a_busy), 0);
        chk("mid_rst_col", 32'(a_out_col), 0);
        chk("mid_rst_pass", 32'(a_pass), 0);
        a_start = 1; tick(1); a_start = 0;
        chk("mid_rst_start_ignored", 32'(a_busy), 0);

        // STRIDE=2 and STRIDE=N single pass
        b_seed = 11'h5A3; b_seed_valid = 1; tick(1); b_seed_valid = 0;
        for (int j = 0; j < 8; j += 2) qb.push_back(ent(tab5[j], j, j == 6));
        qc.push_back(ent(4'h3, 0, 1));
        b_start = 1; tick(1); b_start = 0;
        tick(1);
        chk("c_busy", 32'(c_busy), 0);
        chk("c_pass", 32'(c_pass), 1);
        tick(3);
        chk("b_busy", 32'(b_busy), 0);
        chk("b_pass", 32'(b_pass), 1);
        chk("b_seed_ready", 32'(b_seed_ready), 1);

        // STRIDE=N in continuous mode: two back-to-back single-column passes
        for (int j = 0; j < 8; j += 2) qb.push_back(ent(tab5[j], j, j == 6));
        qc.push_back(ent(4'h3, 0, 1));
        qc.push_back(ent(4'h3, 0, 1));
        c_cont = 1; b_start = 1; tick(1); b_start = 0;
        tick(1);
        c_cont = 0;
        tick(1);
        chk("c_cont_busy", 32'(c_busy), 0);
        chk("c_cont_pass", 32'(c_pass), 3);
        tick(2);
        chk("b2_pass", 32'(b_pass), 2);

        tick(2);
        chk("qa_drained", 32'(qa.size()), 0);
        chk("qb_drained", 32'(qb.size()), 0);
        chk("qc_drained", 32'(qc.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
